// File: rtl/mem_pkg.sv
// Shared encodings for the M-stage memory access unit: memory op codes, FSM states,
// and op classification helpers.
package mem_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] LW       = 4'd1;
  localparam logic [3:0] LH       = 4'd2;
  localparam logic [3:0] LHU      = 4'd3;
  localparam logic [3:0] LB       = 4'd4;
  localparam logic [3:0] LBU      = 4'd5;
  localparam logic [3:0] SW       = 4'd6;
  localparam logic [3:0] SH       = 4'd7;
  localparam logic [3:0] SB       = 4'd8;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic logic is_store(input logic [3:0] op);
    return op inside {SW, SH, SB};
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return op inside {LW, LH, LHU, LB, LBU};
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load data extender: selects the addressed half/byte from a bus word and
// sign/zero-extends it; stores and unknown ops produce zero.
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [3:0]  op_i,
  output logic [31:0] data_o
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half     = lane_i[1] ? word_i[31:16] : word_i[15:0];
    byte_sel = word_i[7:0];
    case (lane_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase

    data_o = '0;
    case (op_i)
      LW:      data_o = word_i;
      LH:      data_o = {{16{half[15]}}, half};
      LHU:     data_o = {16'h0000, half};
      LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data_o = {24'h000000, byte_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: one req/ready bus transaction per access, stalling the pipeline
// until DONE. Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MemOpM,
  input  logic [31:0] ResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErrM,
  output logic        ExcAdM,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  localparam logic             TimeoutEn  = (BUS_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(BUS_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       lane_q, lane_d;
  logic [3:0]       op_q, op_d;
  logic             err_q, err_d;
  logic             access, done, req, misalign, exc_flag;
  logic [31:0]      ext_data;
  logic [3:0]       byteen;
  logic [31:0]      wdata;

  assign access = (MemOpM != MEM_NONE);
  assign done   = (state_q == StDone);

`ifdef MEM_ALIGN_CHECK_EN
  logic exc_q;

  always_comb begin
    misalign = 1'b0;
    case (MemOpM)
      LW, SW:      misalign = (ResultM[1:0] != 2'b00);
      LH, LHU, SH: misalign = ResultM[0];
      default:     misalign = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_q <= 1'b0;
    end else if (state_q == StIdle) begin
      exc_q <= access && misalign;
    end
  end

  assign exc_flag = done && exc_q;
`else
  assign misalign = 1'b0;
  assign exc_flag = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    lane_d  = lane_q;
    op_d    = op_q;
    err_d   = err_q;
    req     = 1'b0;
    case (state_q)
      StIdle: begin
        req   = access && !misalign;
        cnt_d = '0;
        err_d = 1'b0;
        if (access && misalign) begin
          state_d = StDone;
          rdata_d = '0;
          op_d    = MemOpM;
        end else if (req && m_ready) begin
          state_d = StDone;
          rdata_d = m_rdata;
          lane_d  = ResultM[1:0];
          op_d    = MemOpM;
        end else if (access) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        req   = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (m_ready) begin
          state_d = StDone;
          cnt_d   = '0;
          rdata_d = m_rdata;
          lane_d  = ResultM[1:0];
          op_d    = MemOpM;
        end else if (TimeoutEn && (cnt_d == TimeoutCnt)) begin
          // Abort with zero data; the error flag reaches BusErrM in DONE.
          state_d = StDone;
          cnt_d   = '0;
          err_d   = 1'b1;
          rdata_d = '0;
          op_d    = MemOpM;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      lane_q  <= '0;
      op_q    <= MEM_NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      lane_q  <= lane_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  load_ext u_load_ext (
    .word_i (rdata_q),
    .lane_i (lane_q),
    .op_i   (op_q),
    .data_o (ext_data)
  );

  always_comb begin
    byteen = 4'b0000;
    wdata  = '0;
    case (MemOpM)
      SW: begin
        byteen = 4'b1111;
        wdata  = WriteDataM;
      end
      SH: begin
        byteen = ResultM[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{WriteDataM[15:0]}};
      end
      SB: begin
        byteen = 4'b0001 << ResultM[1:0];
        wdata  = {4{WriteDataM[7:0]}};
      end
      default: begin
        byteen = 4'b0000;
        wdata  = '0;
      end
    endcase
  end

  assign m_req     = !reset && req;
  assign m_we      = !reset && is_store(MemOpM);
  assign m_addr    = reset ? '0 : {ResultM[31:2], 2'b00};
  assign m_byteen  = reset ? '0 : byteen;
  assign m_wdata   = reset ? '0 : wdata;
  assign StallM    = !reset && access && !done;
  assign ReadDataM = (!reset && done && !exc_flag) ? ext_data : '0;
  assign BusErrM   = !reset && done && err_q;
  assign ExcAdM    = !reset && exc_flag;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected DONE-cycle results are queued per access
// and popped by a negedge monitor; a latency-programmable memory model answers requests.
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        exc;
    int          stalls;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  MemOpM;
  logic [31:0] ResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        BusErrM;
  logic        ExcAdM;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_byteen;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  int   checks;
  int   failures;
  int   cur_wait;
  int   req_cycles;
  logic idle_ready;
  exp_t sb_q[$];

  mem_access_unit #(
    .BUS_TIMEOUT (4),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemOpM     (MemOpM),
    .ResultM    (ResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .BusErrM    (BusErrM),
    .ExcAdM     (ExcAdM),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_byteen   (m_byteen),
    .m_wdata    (m_wdata),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers after cur_wait unanswered request cycles.
  assign m_ready = idle_ready | (m_req && (req_cycles == cur_wait));

  always @(posedge clk) begin
    if (!m_req || m_ready) req_cycles <= 0;
    else                   req_cycles <= req_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: counts stall cycles per access and scores the DONE cycle.
  initial begin
    exp_t e;
    int   stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_cnt = 0;
      end else if (MemOpM != MEM_NONE) begin
        if (StallM) begin
          stall_cnt++;
        end else begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("rdata", ReadDataM, e.rd);
            chk("buserr", 32'(BusErrM), 32'(e.err));
            chk("excad", 32'(ExcAdM), 32'(e.exc));
            chk("stalls", 32'(stall_cnt), 32'(e.stalls));
            chk("done_req", 32'(m_req), 32'd0);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int waits, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic exp_exc, input int exp_stalls);
    exp_t e;
    bit   first;
    bit   fin;
    e = '{rd: exp_rd, err: exp_err, exc: exp_exc, stalls: exp_stalls};
    sb_q.push_back(e);
    MemOpM     = op;
    ResultM    = addr;
    WriteDataM = wd;
    m_rdata    = rdata;
    cur_wait   = waits;
    first      = 1'b1;
    fin        = 1'b0;
    for (int i = 0; i < 64 && !fin; i++) begin
      @(negedge clk);
      if (first) begin
        first = 1'b0;
        chk("req_cycle0", 32'(m_req), 32'(!exp_exc));
        if (m_req) begin
          chk("m_addr", m_addr, {addr[31:2], 2'b00});
          chk("m_we", 32'(m_we), 32'(exp_be != 4'b0000));
          chk("m_byteen", 32'(m_byteen), 32'(exp_be));
          chk("m_wdata", m_wdata, exp_wd);
        end
      end
      if (!StallM) fin = 1'b1;
    end
    if (!fin) chk("done_wait_expired", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    checks     = 0;
    failures   = 0;
    cur_wait   = 0;
    idle_ready = 1'b1;
    reset      = 1'b1;
    MemOpM     = SW;
    ResultM    = 32'h0000_3000;
    WriteDataM = 32'hFFFF_FFFF;
    m_rdata    = 32'h5555_5555;

    // Outputs held at zero while reset is asserted, even with an op present.
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(m_req), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_we", 32'(m_we), 32'd0);
    chk("rst_addr", m_addr, 32'd0);
    chk("rst_byteen", 32'(m_byteen), 32'd0);
    chk("rst_wdata", m_wdata, 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_flags", 32'({BusErrM, ExcAdM}), 32'd0);
    @(posedge clk);
    #1;
    MemOpM     = MEM_NONE;
    reset      = 1'b0;

    // m_ready without a request must not start anything.
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready_req", 32'(m_req), 32'd0);
      chk("idle_ready_stall", 32'(StallM), 32'd0);
    end
    @(posedge clk);
    #1;
    idle_ready = 1'b0;

    //     op   addr           wdata          rdata          wt  be       exp_wd         exp_rd
    run_op(LW,  32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 0, 4'b0000, 32'h0,         32'hDEAD_BEEF, 0, 0, 1);
    run_op(SB,  32'h0000_2003, 32'h0000_00A5, 32'h1111_1111, 3, 4'b1000, 32'hA5A5_A5A5, 32'h0,         0, 0, 4);
    run_op(LB,  32'h0000_1002, 32'h0,         32'h1280_3456, 0, 4'b0000, 32'h0,         32'hFFFF_FF80, 0, 0, 1);
    run_op(LBU, 32'h0000_1002, 32'h0,         32'h1280_3456, 1, 4'b0000, 32'h0,         32'h0000_0080, 0, 0, 2);
    run_op(LH,  32'h0000_1002, 32'h0,         32'h1280_3456, 0, 4'b0000, 32'h0,         32'h0000_1280, 0, 0, 1);
    run_op(LB,  32'h0000_1001, 32'h0,         32'h1280_3456, 2, 4'b0000, 32'h0,         32'h0000_0034, 0, 0, 3);
    run_op(LHU, 32'h0000_1000, 32'h0,         32'h1234_F00D, 1, 4'b0000, 32'h0,         32'h0000_F00D, 0, 0, 2);
    run_op(LH,  32'h0000_1000, 32'h0,         32'h1234_F00D, 0, 4'b0000, 32'h0,         32'hFFFF_F00D, 0, 0, 1);
    run_op(SH,  32'h0000_3002, 32'h0000_BEEF, 32'h2222_2222, 2, 4'b1100, 32'hBEEF_BEEF, 32'h0,         0, 0, 3);
    run_op(SW,  32'h0000_3000, 32'hCAFE_F00D, 32'h3333_3333, 0, 4'b1111, 32'hCAFE_F00D, 32'h0,         0, 0, 1);
    // Timeout of 4 BUSY cycles, then an immediate zero-wait access proves IDLE follows DONE.
    run_op(LW,  32'h0000_4000, 32'h0,         32'h7777_7777, 1000, 4'b0000, 32'h0,      32'h0,         1, 0, 5);
    run_op(LW,  32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 0, 4'b0000, 32'h0,         32'hDEAD_BEEF, 0, 0, 1);
`ifdef MEM_ALIGN_CHECK_EN
    run_op(LW,  32'h0000_1002, 32'h0,         32'h1122_3344, 0, 4'b0000, 32'h0,         32'h0,         0, 1, 1);
`else
    run_op(LW,  32'h0000_1002, 32'h0,         32'h1122_3344, 0, 4'b0000, 32'h0,         32'h1122_3344, 0, 0, 1);
`endif

    // Reset in the second BUSY cycle abandons the request immediately.
    MemOpM   = LW;
    ResultM  = 32'h0000_5000;
    cur_wait = 1000;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req", 32'(m_req), 32'd0);
    chk("midrst_stall", 32'(StallM), 32'd0);
    chk("midrst_rdata", ReadDataM, 32'd0);
    chk("midrst_addr", m_addr, 32'd0);
    chk("midrst_flags", 32'({BusErrM, ExcAdM}), 32'd0);
    @(posedge clk);
    #1;
    MemOpM = MEM_NONE;
    reset  = 1'b0;
    run_op(LW,  32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 0, 4'b0000, 32'h0,         32'hDEAD_BEEF, 0, 0, 1);
    MemOpM = MEM_NONE;

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- M-stage consumer of the EX/ME pipeline register outputs: MemOpM, ResultM (address) and WriteDataM.
- Issues each load/store as one transaction on a req/ready data-memory bus.
- Stalls the pipeline until the transaction completes.
- Returns sign/zero-extended load data to the ME/WB register; generates byte enables and lane-replicated store data.

Parameters:
- BUS_TIMEOUT, 255: maximum cycles in BUSY without m_ready before a bus error; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy BUS_TIMEOUT < 2**CNT_W.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- MemOpM  input  4  M-stage memory op (encoding in package).
- ResultM  input  32  byte address from EX.
- WriteDataM  input  32  forwarded store data.
- ReadDataM  output  32  extended load result; valid in the DONE cycle.
- StallM  output  1  freeze F/D/E/M registers and insert a W bubble.
- BusErrM  output  1  timeout flag; valid in the DONE cycle.
- ExcAdM  output  1  misalignment flag (feature only; 0 otherwise).
- m_req  output  1  bus request.
- m_we  output  1  1 = store.
- m_addr  output  32  {ResultM[31:2],2'b00}.
- m_byteen  output  4  byte lane enables.
- m_wdata  output  32  lane-replicated store data.
- m_ready  input  1  memory accepted/completed the request this cycle.
- m_rdata  input  32  read word, valid when m_ready=1.

Behaviour:
- access = MemOpM != MEM_NONE.
- is_store = MemOpM in {SW, SH, SB}.
- FSM states: IDLE, BUSY, DONE. Reset: state=IDLE, wait counter=0, data register=0, err register=0.
- While reset=1, all outputs are 0.
- IDLE: m_req=access. If m_req and m_ready, go to DONE. Else if access, go to BUSY.
- BUSY: m_req=1 and the wait counter increments. On m_ready, go to DONE. If the counter reaches BUS_TIMEOUT (nonzero), set the err register, load data 0 and go to DONE.
- DONE: m_req=0, StallM=0, and ReadDataM/BusErrM come from the registers. Next state is always IDLE; the pipeline advances on this edge.
- StallM = access && state != DONE.
- Latency with zero-wait memory: 1 stall cycle plus the DONE cycle.
- With N wait cycles: N+1 stall cycles.
- Bus-side rule: m_addr, m_we, m_byteen and m_wdata are combinational from the M inputs. They are stable during a request because StallM freezes the EX/ME register.
- On a read, m_rdata is captured along with ResultM[1:0] and MemOpM.
- Byte enables:
  - SW: 1111.
  - SH: addr[1] ? 1100 : 0011.
  - SB: 0001 << addr[1:0].
  - Loads: 0000 with m_we=0.
- Store data: SW word; SH {h,h}; SB {b,b,b,b}, where h/b are the low bits of WriteDataM.
- Load extension:
  - LW: word.
  - LH/LHU: half selected by addr[1], sign/zero-extended.
  - LB/LBU: byte selected by addr[1:0], sign/zero-extended.
- ReadDataM is 0 outside DONE and for stores.
- m_ready while m_req=0 is ignored.
- Reset asserted mid-BUSY abandons the request (m_req drops the same cycle) and returns to IDLE; the memory must tolerate an abandoned request.
- Back-to-back accesses: after DONE, the next instruction enters IDLE and issues on the following cycle. No combining.
- A stall from another unit does not affect this FSM; this unit only raises StallM.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A misaligned access is suppressed: LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]=1.
  - No m_req is issued. The FSM goes IDLE to DONE directly (1 stall cycle).
  - In DONE, ExcAdM=1 and ReadDataM=0.
- Undefined: ExcAdM is tied 0; low address bits are ignored beyond lane selection (word address used).

Decomposition:
- Shared package mem_pkg: MemOp encodings (MEM_NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8), FSM state encodings, and helper functions is_store/is_load.
- Sub-module load_ext (combinational extender from word, addr[1:0] and MemOp) is the natural split; the FSM, counter and store packing remain in the top.

Test Plan:
- LW at 0x0000_1004, m_ready tied 1, m_rdata=0xDEADBEEF:
  - Cycle 0: m_req=1, StallM=1.
  - Cycle 1: DONE, StallM=0, ReadDataM=0xDEADBEEF.
- SB at 0x0000_2003, WriteDataM=0x000000A5, m_ready after 3 cycles: m_byteen=1000, m_wdata=0xA5A5A5A5, StallM held 4 cycles, ReadDataM=0.
- LB/LBU at addr 0x1002 with m_rdata=0x12_80_34_56: LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at addr 0x1002 gives 0x00001280.
- BUS_TIMEOUT=4, m_ready never asserted: BUSY for 4 cycles, then DONE with BusErrM=1 and ReadDataM=0; next cycle IDLE.
- Reset asserted in the 2nd BUSY cycle: m_req=0 the same cycle, state IDLE after the edge, all outputs 0.
- With MEM_ALIGN_CHECK_EN, LW at 0x1002: m_req never asserted, 1 stall cycle, ExcAdM=1 in DONE.
